// File: rtl/bubctrlfe_mc.sv
// Bubble-memory control front end: internal rotation-phase counter plus per-channel
// shift-start, shift-enable, replicator, swap-gate and bootloop strobes (all active-low).
module bubctrlfe_mc #(
  parameter int CHANNELS   = 2,
  parameter int CH_W       = 1,
  parameter int ROT_LEN    = 20,
  parameter int BOOT_PH    = 0,
  parameter int BSEN_PH    = 1,
  parameter int REP_PH     = 2,
  parameter int SWAP_PH    = 3,
  parameter int REP_END_PH = 16,
  parameter int BSS_PH     = 17,
  parameter int REP_DIV    = 2
) (
  input  logic                i_MCLK,
  input  logic                i_RST,
  input  logic                i_CLK2M_PCEN_n,
  input  logic                i_ROT_SYNC,
  input  logic                i_SYS_RUN_FLAG_SET_n,
  input  logic [CH_W-1:0]     i_CH_SEL,
  input  logic                i_ABSPGCNTR_CNT_START,
  input  logic                i_ABSPGCNTR_CNT_STOP,
  input  logic                i_VALPG_ACC_FLAG,
  input  logic                i_BMODE_n,
  input  logic                i_REP_START,
  input  logic                i_SWAP_START,
  output logic [4:0]          o_ROT_PH,
  output logic [CHANNELS-1:0] o_BOOTEN_n,
  output logic [CHANNELS-1:0] o_BSS_n,
  output logic [CHANNELS-1:0] o_BSEN_n,
  output logic [CHANNELS-1:0] o_REPEN_n,
  output logic [CHANNELS-1:0] o_SWAPEN_n
);

  localparam logic [4:0] LAST_P    = 5'(ROT_LEN - 1);
  localparam logic [4:0] BOOT_P    = 5'(BOOT_PH);
  localparam logic [4:0] BSEN_P    = 5'(BSEN_PH);
  localparam logic [4:0] REP_P     = 5'(REP_PH);
  localparam logic [4:0] SWAP_P    = 5'(SWAP_PH);
  localparam logic [4:0] REP_END_P = 5'(REP_END_PH);
  localparam logic [4:0] BSS_P     = 5'(BSS_PH);
  localparam logic [3:0] REP_MAX   = 4'(REP_DIV - 1);

  logic [4:0]          phase;
  logic [CHANNELS-1:0] booten_n, bss_n, bsen_n, repen_n, swapen_n;
  logic [CHANNELS-1:0] sel, rep_fire;
  logic [3:0]          rep_cnt [CHANNELS];
  logic                tick;

  assign tick = !i_CLK2M_PCEN_n;

  // An out-of-range channel select matches no channel, so commands to it vanish.
  always_comb begin
    sel      = '0;
    rep_fire = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      sel[ch]      = (int'(i_CH_SEL) == ch);
      rep_fire[ch] = (!booten_n[ch] && !bsen_n[ch] && (rep_cnt[ch] == 4'd0))
                     || (sel[ch] && i_REP_START);
    end
  end

  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      phase    <= '0;
      booten_n <= '0;
      bss_n    <= '1;
      bsen_n   <= '1;
      repen_n  <= '1;
      swapen_n <= '1;
      for (int ch = 0; ch < CHANNELS; ch++) rep_cnt[ch] <= REP_MAX;
    end else if (tick) begin
      if (i_ROT_SYNC || (phase == LAST_P)) phase <= '0;
      else                                 phase <= phase + 5'd1;

      if (i_BMODE_n && (phase == BOOT_P)) booten_n <= '1;

      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (!i_SYS_RUN_FLAG_SET_n) bss_n[ch] <= 1'b1;
        else if (sel[ch] && i_ABSPGCNTR_CNT_START && (phase == BSS_P)) bss_n[ch] <= 1'b0;

        if (sel[ch] && i_ABSPGCNTR_CNT_STOP) bsen_n[ch] <= 1'b1;
        else if (sel[ch] && i_ABSPGCNTR_CNT_START && (phase == BSEN_P)) bsen_n[ch] <= 1'b0;

        // Counter parks at REP_DIV-1 so the first full rotation after enable replicates.
        if (booten_n[ch] || bsen_n[ch]) rep_cnt[ch] <= REP_MAX;
        else if (phase == BSEN_P) rep_cnt[ch] <= (rep_cnt[ch] == REP_MAX) ? 4'd0 : rep_cnt[ch] + 4'd1;

        if (phase == REP_END_P) repen_n[ch] <= 1'b1;
        else if ((phase == REP_P) && rep_fire[ch]) repen_n[ch] <= 1'b0;

        if (phase == BSS_P) swapen_n[ch] <= 1'b1;
        else if ((phase == SWAP_P) && sel[ch] && i_SWAP_START && i_VALPG_ACC_FLAG)
          swapen_n[ch] <= 1'b0;
      end
    end
  end

  assign o_ROT_PH   = phase;
  assign o_BOOTEN_n = booten_n;
  assign o_BSS_n    = bss_n;
  assign o_BSEN_n   = bsen_n;
  assign o_REPEN_n  = repen_n;
  assign o_SWAPEN_n = swapen_n;

endmodule

// File: tb/tb_bubctrlfe_mc.sv
// Bench for bubctrlfe_mc: directed scenarios plus random stimulus against a rotation-level
// model; a second instance with REP_DIV=3 checks the replication divider.
module tb_bubctrlfe_mc;
  localparam int CH = 2;
  localparam int RL = 20;

  logic clk = 1'b0;
  logic rst, pcen_n, rot_sync, run_n, start, stop, valpg, bmode_n, rep_start, swap_start;
  logic [0:0] ch_sel;
  logic [4:0] rot_ph, rot_ph3;
  logic [1:0] booten_n, bss_n, bsen_n, repen_n, swapen_n;
  logic [1:0] booten3, bss3, bsen3, repen3, swapen3;
  logic [16:0] act;
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  bubctrlfe_mc dut (
    .i_MCLK(clk), .i_RST(rst), .i_CLK2M_PCEN_n(pcen_n), .i_ROT_SYNC(rot_sync),
    .i_SYS_RUN_FLAG_SET_n(run_n), .i_CH_SEL(ch_sel), .i_ABSPGCNTR_CNT_START(start),
    .i_ABSPGCNTR_CNT_STOP(stop), .i_VALPG_ACC_FLAG(valpg), .i_BMODE_n(bmode_n),
    .i_REP_START(rep_start), .i_SWAP_START(swap_start), .o_ROT_PH(rot_ph),
    .o_BOOTEN_n(booten_n), .o_BSS_n(bss_n), .o_BSEN_n(bsen_n), .o_REPEN_n(repen_n),
    .o_SWAPEN_n(swapen_n));

  bubctrlfe_mc #(.REP_DIV(3)) dut3 (
    .i_MCLK(clk), .i_RST(rst), .i_CLK2M_PCEN_n(pcen_n), .i_ROT_SYNC(rot_sync),
    .i_SYS_RUN_FLAG_SET_n(run_n), .i_CH_SEL(ch_sel), .i_ABSPGCNTR_CNT_START(start),
    .i_ABSPGCNTR_CNT_STOP(stop), .i_VALPG_ACC_FLAG(valpg), .i_BMODE_n(bmode_n),
    .i_REP_START(rep_start), .i_SWAP_START(swap_start), .o_ROT_PH(rot_ph3),
    .o_BOOTEN_n(booten3), .o_BSS_n(bss3), .o_BSEN_n(bsen3), .o_REPEN_n(repen3),
    .o_SWAPEN_n(swapen3));

  assign act = {rot_ph, booten_n, bss_n, bsen_n, repen_n, swapen_n, repen3};

  // Model: active-high "strobe on" flags; m_n counts rotations since replication was armed.
  int m_ph;
  bit [1:0] m_boot, m_bss, m_bsen, m_swap;
  bit [1:0] m_rep [2];
  int m_n [2][2];
  int divs [2] = '{2, 3};

  task automatic model_edge();
    int p, cs;
    bit valid, active, fire;
    bit [1:0] boot, bss, bsen, swap;
    bit [1:0] rep [2];
    if (rst) begin
      m_ph = 0; m_boot = 2'b11; m_bss = '0; m_bsen = '0; m_swap = '0;
      for (int k = 0; k < 2; k++) begin
        m_rep[k] = '0;
        for (int c = 0; c < CH; c++) m_n[k][c] = 0;
      end
      return;
    end
    if (pcen_n) return;
    p = m_ph; cs = int'(ch_sel); valid = (cs < CH);
    boot = m_boot; bss = m_bss; bsen = m_bsen; swap = m_swap; rep = m_rep;
    if (!run_n) bss = '0;
    else if (valid && start && p == 17) bss[cs] = 1'b1;
    if (valid && stop) bsen[cs] = 1'b0;
    else if (valid && start && p == 1) bsen[cs] = 1'b1;
    if (bmode_n && p == 0) boot = '0;
    if (p == 17) swap = '0;
    else if (p == 3 && valid && swap_start && valpg) swap[cs] = 1'b1;
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < CH; c++) begin
        active = m_boot[c] && m_bsen[c];
        fire = (active && (m_n[k][c] % divs[k]) == (1 % divs[k])) || (valid && rep_start && cs == c);
        if (p == 16) rep[k][c] = 1'b0;
        else if (p == 2 && fire) rep[k][c] = 1'b1;
        if (!active) m_n[k][c] = 0;
        else if (p == 1) m_n[k][c]++;
      end
    m_ph = rot_sync ? 0 : (p + 1) % RL;
    m_boot = boot; m_bss = bss; m_bsen = bsen; m_swap = swap; m_rep = rep;
  endtask

  function automatic logic [16:0] exp_bus();
    return {5'(m_ph), ~m_boot, ~m_bss, ~m_bsen, ~m_rep[0], ~m_swap, ~m_rep[1]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; pcen_n = 0; rot_sync = 0; run_n = 1; ch_sel = 0; start = 0; stop = 0;
    valpg = 0; bmode_n = 0; rep_start = 0; swap_start = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; cyc(); rst = 0;
  endtask

  task automatic advance_to(input int ph);
    for (int i = 0; i < RL + 1 && m_ph != ph; i++) cyc();
  endtask

  task automatic test_reset();
    idle_inputs();
    pcen_n = 1; rst = 1; cyc(); rst = 0; pcen_n = 0;
    checks++;
    if ({rot_ph, booten_n, bss_n, bsen_n, repen_n, swapen_n} !== {5'd0, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11}) begin
      fails++;
      $display("FAIL reset_state: got %h required %h", {rot_ph, booten_n, bss_n, bsen_n, repen_n, swapen_n},
               {5'd0, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11});
    end
    checks++;
    if (act !== exp_bus()) begin fails++; $display("FAIL reset_bus: got %h required %h", act, exp_bus()); end
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      cyc();
      checks++;
      if (rot_ph !== 5'((i + 1) % RL)) begin
        fails++; $display("FAIL idle_phase: tick %0d got %0d required %0d", i, rot_ph, (i + 1) % RL);
      end
      checks++;
      if (act !== exp_bus()) begin fails++; $display("FAIL idle_bus: tick %0d got %h required %h", i, act, exp_bus()); end
    end
  endtask

  task automatic test_shift();
    do_reset();
    ch_sel = 1; start = 1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      checks++;
      if (act !== exp_bus()) begin fails++; $display("FAIL shift_bus: tick %0d got %h required %h", i, act, exp_bus()); end
    end
    start = 0;
    checks++;
    if ({bsen_n, bss_n} !== 4'b0101) begin fails++; $display("FAIL shift_set: got %b required 0101", {bsen_n, bss_n}); end
    run_n = 0; cyc(); run_n = 1;
    checks++;
    if (bss_n !== 2'b11) begin fails++; $display("FAIL shift_runflag: got %b required 11", bss_n); end
  endtask

  task automatic test_replicate();
    int cnt2, cnt3;
    do_reset();
    ch_sel = 0; start = 1; cyc(); cyc(); start = 0;
    cnt2 = 0; cnt3 = 0;
    for (int i = 0; i < 6 * RL; i++) begin
      cyc();
      if (repen_n[0] == 1'b0) cnt2++;
      if (repen3[0] == 1'b0) cnt3++;
      checks++;
      if (act !== exp_bus()) begin fails++; $display("FAIL rep_bus: tick %0d got %h required %h", i, act, exp_bus()); end
    end
    checks++;
    if (cnt2 != 42) begin fails++; $display("FAIL rep_div2_low: got %0d required 42", cnt2); end
    checks++;
    if (cnt3 != 28) begin fails++; $display("FAIL rep_div3_low: got %0d required 28", cnt3); end
  endtask

  task automatic test_boot_exit();
    int cnt1, cnt0;
    do_reset();
    bmode_n = 1; cyc();
    checks++;
    if (booten_n !== 2'b11) begin fails++; $display("FAIL boot_exit: got %b required 11", booten_n); end
    ch_sel = 0; start = 1; cyc(); start = 0;
    ch_sel = 1; rep_start = 1; cyc(); rep_start = 0;
    cnt1 = (repen_n[1] == 1'b0) ? 1 : 0;
    cnt0 = 0;
    for (int i = 0; i < 2 * RL; i++) begin
      cyc();
      if (repen_n[1] == 1'b0) cnt1++;
      if (repen_n[0] == 1'b0) cnt0++;
      checks++;
      if (act !== exp_bus()) begin fails++; $display("FAIL boot_bus: tick %0d got %h required %h", i, act, exp_bus()); end
    end
    checks++;
    if (cnt1 != 14 || cnt0 != 0) begin
      fails++; $display("FAIL boot_rep_pulse: got %0d/%0d required 14/0", cnt1, cnt0);
    end
    checks++;
    if (booten_n !== 2'b11) begin fails++; $display("FAIL boot_stays: got %b required 11", booten_n); end
  endtask

  task automatic test_collision();
    int cnt;
    do_reset();
    ch_sel = 0;
    advance_to(1);
    start = 1; stop = 1; cyc(); start = 0; stop = 0;
    checks++;
    if (bsen_n !== 2'b11) begin fails++; $display("FAIL start_stop: got %b required 11", bsen_n); end
    advance_to(3);
    swap_start = 1; valpg = 0; cyc(); swap_start = 0;
    checks++;
    if (swapen_n !== 2'b11) begin fails++; $display("FAIL swap_noflag: got %b required 11", swapen_n); end
    advance_to(3);
    swap_start = 1; valpg = 1; cyc(); swap_start = 0; valpg = 0;
    cnt = (swapen_n[0] == 1'b0) ? 1 : 0;
    for (int i = 0; i < RL; i++) begin
      cyc();
      if (swapen_n[0] == 1'b0) cnt++;
      checks++;
      if (act !== exp_bus()) begin fails++; $display("FAIL swap_bus: tick %0d got %h required %h", i, act, exp_bus()); end
    end
    checks++;
    if (cnt != 14) begin fails++; $display("FAIL swap_len: got %0d required 14", cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ch_sel = 1;
    advance_to(2);
    rep_start = 1; cyc(); rep_start = 0;
    advance_to(10);
    checks++;
    if (repen_n !== 2'b01) begin fails++; $display("FAIL mid_setup: got %b required 01", repen_n); end
    rst = 1; pcen_n = 1; cyc(); rst = 0; pcen_n = 0;
    checks++;
    if ({rot_ph, repen_n, booten_n} !== {5'd0, 2'b11, 2'b00}) begin
      fails++; $display("FAIL mid_reset: got %h required %h", {rot_ph, repen_n, booten_n}, {5'd0, 2'b11, 2'b00});
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      pcen_n     = ($urandom_range(0, 3) == 0);
      rot_sync   = ($urandom_range(0, 49) == 0);
      run_n      = !($urandom_range(0, 29) == 0);
      ch_sel     = 1'($urandom);
      start      = ($urandom_range(0, 3) == 0);
      stop       = ($urandom_range(0, 15) == 0);
      valpg      = 1'($urandom);
      bmode_n    = ($urandom_range(0, 199) == 0);
      rep_start  = ($urandom_range(0, 9) == 0);
      swap_start = ($urandom_range(0, 3) == 0);
      cyc();
      checks++;
      if (act !== exp_bus()) begin fails++; $display("FAIL random_bus: tick %0d got %h required %h", i, act, exp_bus()); end
    end
    idle_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle();
    test_shift();
    test_replicate();
    test_boot_exit();
    test_collision();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/bubctrlfe_mc.md
Name: bubctrlfe_mc

Overview:
Multi-channel, parametrised bubble-memory control front end. Generates active-low shift-start, shift-enable, replicator, swap-gate and bootloop strobes for CHANNELS bubble modules. An internal rotation-phase counter replaces the external one-hot 20-phase bus. Phase slots and rotation length are parameters. Bootloop replication fires every REP_DIV rotations instead of a fixed alternate-rotation toggle. Sits between the page-counter/command logic and the bubble drive outputs.

Parameters:
CHANNELS, 2, number of bubble modules (1..8)
CH_W, 1, width of channel index (clog2(CHANNELS), min 1)
ROT_LEN, 20, phases per field rotation (4..32)
BOOT_PH, 0, phase sampling bootloop-mode
BSEN_PH, 1, phase for shift-enable set and replication rotation count
REP_PH, 2, replicator turn-on phase
SWAP_PH, 3, swap-gate turn-on phase
REP_END_PH, 16, replicator turn-off phase
BSS_PH, 17, shift-start set phase; also SWAP_END_PH
REP_DIV, 2, bootloop replicate every Nth rotation (1..15)

Ports:
i_MCLK  in  1  master clock
i_RST  in  1  synchronous reset, active-high
i_CLK2M_PCEN_n  in  1  phase tick enable, active-low
i_ROT_SYNC  in  1  on tick, forces phase to 0
i_SYS_RUN_FLAG_SET_n  in  1  active-low, clears BSS on all channels
i_CH_SEL  in  CH_W  channel targeted by commands
i_ABSPGCNTR_CNT_START  in  1  start shifting on selected channel
i_ABSPGCNTR_CNT_STOP  in  1  stop shifting on selected channel
i_VALPG_ACC_FLAG  in  1  valid-page access qualifier
i_BMODE_n  in  1  high = leave bootloop mode
i_REP_START  in  1  explicit replicate request for selected channel
i_SWAP_START  in  1  swap request for selected channel
o_ROT_PH  out  5  current rotation phase
o_BOOTEN_n  out  CHANNELS  bootloop enable, active-low
o_BSS_n  out  CHANNELS  bubble shift start, active-low
o_BSEN_n  out  CHANNELS  bubble shift enable, active-low
o_REPEN_n  out  CHANNELS  replicator enable, active-low
o_SWAPEN_n  out  CHANNELS  swap gate enable, active-low

Behaviour:
- i_RST is synchronous and overrides the enable. It sets phase=0, all o_BOOTEN_n=0 (bootloop active), and every other output 1. Each rep_cnt=REP_DIV-1.
- All state changes only on a tick: an MCLK edge with i_CLK2M_PCEN_n=0. No tick means all state holds.
- Phase: +1 per tick, wraps ROT_LEN-1 -> 0. i_ROT_SYNC on a tick loads 0 and takes priority over increment.
- All phase tests use the phase value before the tick. Outputs change on that same edge, one registered stage.
- Commands apply only to channel ch==i_CH_SEL. If i_CH_SEL>=CHANNELS, commands are ignored.
- BSS[ch]: set (0) when START and phase==BSS_PH. Cleared (1) for all channels when i_SYS_RUN_FLAG_SET_n=0. Clear wins if both occur.
- BSEN[ch]: set (0) when START and phase==BSEN_PH. Cleared by STOP at any phase. STOP wins over START.
- BOOTEN: all channels cleared to 1 when i_BMODE_n=1 at phase==BOOT_PH. Only reset re-arms it.
- rep_cnt[ch] (4 bits):
  - forced to REP_DIV-1 while BOOTEN[ch]=1 or BSEN[ch]=1.
  - otherwise at phase==BSEN_PH: rep_cnt = (rep_cnt==REP_DIV-1) ? 0 : rep_cnt+1.
- rep_fire[ch] = (BOOTEN[ch]=0 and BSEN[ch]=0 and rep_cnt==0) or (REP_START for ch).
- REPEN[ch]: 0 when rep_fire at phase==REP_PH. 1 at phase==REP_END_PH.
- SWAPEN[ch]: 0 when SWAP_START and VALPG_ACC_FLAG at phase==SWAP_PH. 1 at phase==BSS_PH.
- Phase parameters must be distinct where they pair as on/off. An on/off collision is a configuration error; off has priority.
- Reset mid-rotation abandons all strobes immediately. No partial pulse persists.
- o_ROT_PH is zero-extended to 5 bits.

Test Plan:
1. Reset, then 40 ticks with no commands -> o_ROT_PH runs 0..19,0..19. o_BOOTEN_n=2'b00 and all other outputs 2'b11.
2. CH_SEL=1, START held over phases 1 and 17 -> BSEN_n[1]=0 after phase-1 tick, BSS_n[1]=0 after phase-17 tick. Channel 0 unchanged. RUN_FLAG_SET_n=0 -> BSS_n=2'b11.
3. Bootloop with BSEN_n[0]=0, REP_DIV=2 -> REPEN_n[0] is low from phase 2 to 16 on rotations 1,3,5 only. With REP_DIV=3 -> rotations 1,4,7.
4. BMODE_n=1 at phase 0 -> BOOTEN_n=2'b11 permanently. Replication stops, but REP_START at phase 2 still gives one REPEN pulse.
5. START and STOP on the same phase-1 tick -> BSEN_n stays 1. SWAP_START with VALPG_ACC_FLAG=0 at phase 3 -> no SWAPEN. With flag=1 -> SWAPEN_n low for phases 4..17.
6. i_RST asserted at phase 10 with REPEN active and the enable held high -> next edge gives phase 0, REPEN_n=1, BOOTEN_n=0.
